// File: rtl/scv_pkg.sv
// Shared types and helpers for the scv audio output path.
package scv_pkg;
  localparam logic [7:0] SND_MID = 8'h80;

  typedef logic signed [15:0] pcm_t;
  typedef logic signed [23:0] dcacc_t;

  // Clamp the 20-bit gained difference into 16-bit PCM range.
  function automatic pcm_t sat16(input logic signed [19:0] g);
    if (g > 20'sd32767)       return 16'sh7fff;
    else if (g < -20'sd32768) return 16'sh8000;
    else                      return g[15:0];
  endfunction
endpackage

// File: rtl/scv_audio_tick.sv
// Fractional output-rate divider: one-cycle TICK averaging OUT_HZ per CLK_HZ cycles.
module scv_audio_tick #(
  parameter int CLK_HZ = 28_636_363,
  parameter int OUT_HZ = 48_000
) (
  input  logic CLK_SYS,
  input  logic RST,
  output logic TICK
);
  logic [31:0] acc;
  logic [32:0] nxt;

  // Wider sum so the compare cannot wrap near 2^32.
  assign nxt  = {1'b0, acc} + 33'(OUT_HZ);
  assign TICK = (nxt >= 33'(CLK_HZ));

  always_ff @(posedge CLK_SYS) begin
    if (RST)       acc <= '0;
    else if (TICK) acc <= 32'(nxt - 33'(CLK_HZ));
    else           acc <= nxt[31:0];
  end
endmodule

// File: rtl/scv_audio_out.sv
// 8-bit unsigned core sound -> lowpass, zero-order hold, DC blocker, gain, saturate -> 16-bit PCM.
module scv_audio_out
  import scv_pkg::*;
#(
  parameter int CLK_HZ   = 28_636_363,
  parameter int OUT_HZ   = 48_000,
  parameter int LP_SHIFT = 2,
  parameter int DC_SHIFT = 10
) (
  input  logic        CLK_SYS,
  input  logic        RST,
  input  logic [7:0]  SND_IN,
  input  logic        SND_VALID,
  input  logic        MUTE,
  input  logic [1:0]  VOL,
  output logic [15:0] AUDIO_L,
  output logic [15:0] AUDIO_R,
  output logic        AUDIO_STB
);
  localparam int STAGES = 1;

  logic               tick;
  logic [STAGES:0]    vld_pipe;
  pcm_t               x, lp, hold;
  dcacc_t             dc;
  logic signed [16:0] lp_d, lp_step, diff;
  logic signed [24:0] dc_d, dc_step;
  logic signed [19:0] g;

  scv_audio_tick #(.CLK_HZ(CLK_HZ), .OUT_HZ(OUT_HZ)) u_tick (
    .CLK_SYS (CLK_SYS),
    .RST     (RST),
    .TICK    (tick)
  );

  assign x       = {SND_IN ^ SND_MID, 8'h00};
  assign lp_d    = 17'(x) - 17'(lp);
  assign lp_step = lp_d >>> LP_SHIFT;

  // dc is Q16.8; the difference is taken against the pre-update integer part.
  assign dc_d    = 25'(signed'({hold, 8'h00})) - 25'(dc);
  assign dc_step = dc_d >>> DC_SHIFT;
  assign diff    = 17'(hold) - 17'(signed'(dc[23:8]));
  assign g       = 20'(diff) <<< VOL;

  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      lp       <= '0;
      hold     <= '0;
      dc       <= '0;
      vld_pipe <= '0;
      AUDIO_L  <= '0;
    end else begin
      if (SND_VALID) lp <= 16'(17'(lp) + lp_step);
      // Sample-and-hold sees lp before any same-cycle input update.
      if (tick) hold <= lp;
      vld_pipe <= {vld_pipe[STAGES-1:0], tick};
      if (vld_pipe[0]) begin
        dc      <= 24'(25'(dc) + dc_step);
        AUDIO_L <= MUTE ? 16'h0000 : sat16(g);
      end
    end
  end

  assign AUDIO_STB = vld_pipe[STAGES];
  assign AUDIO_R   = AUDIO_L;
endmodule

// File: tb/tb_scv_audio_out.sv
// Directed bench for scv_audio_out: reset, rate, step/DC decay, saturation, coincidence, mute.
module tb_scv_audio_out;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, snd_valid, mute;
  logic [7:0]  snd_in;
  logic [1:0]  vol;
  logic [15:0] a_l, a_r, b_l, b_r, c_l, c_r;
  logic        a_stb, b_stb, c_stb;

  int checks = 0;
  int errors = 0;
  int dc_m   = 0;  // reference DC state, Q16.8 as integer
  int hold_m = 0;  // lp value the next tick will capture (LP_SHIFT=0 -> last x)

  // Fast exact-rate instance with short DC constant for value tests.
  scv_audio_out #(.CLK_HZ(100), .OUT_HZ(10), .LP_SHIFT(0), .DC_SHIFT(4)) dut_a (
    .CLK_SYS(clk), .RST(rst), .SND_IN(snd_in), .SND_VALID(snd_valid), .MUTE(mute), .VOL(vol),
    .AUDIO_L(a_l), .AUDIO_R(a_r), .AUDIO_STB(a_stb));
  // Fractional-rate instance.
  scv_audio_out #(.CLK_HZ(1000), .OUT_HZ(3)) dut_b (
    .CLK_SYS(clk), .RST(rst), .SND_IN(snd_in), .SND_VALID(snd_valid), .MUTE(mute), .VOL(vol),
    .AUDIO_L(b_l), .AUDIO_R(b_r), .AUDIO_STB(b_stb));
  // Same timing as dut_a but with the lowpass active.
  scv_audio_out #(.CLK_HZ(100), .OUT_HZ(10), .LP_SHIFT(2), .DC_SHIFT(10)) dut_c (
    .CLK_SYS(clk), .RST(rst), .SND_IN(snd_in), .SND_VALID(snd_valid), .MUTE(mute), .VOL(vol),
    .AUDIO_L(c_l), .AUDIO_R(c_r), .AUDIO_STB(c_stb));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_stb(output logic signed [15:0] v);
    int n = 0;
    step();
    while (!a_stb && n < 40) begin step(); n++; end
    if (!a_stb) chk("stb_timeout", a_stb, 1);
    v = a_l;
  endtask

  task automatic model(input int hold, output int exp);
    int diff, g;
    diff = hold - (dc_m >>> 8);
    dc_m = dc_m + ((hold * 256 - dc_m) >>> 4);
    g = diff * (1 << vol);
    if (g > 32767) g = 32767;
    else if (g < -32768) g = -32768;
    exp = mute ? 0 : g;
  endtask

  // Apply one sample; called just after a strobe, so it never coincides with a tick.
  task automatic apply(input logic [7:0] s);
    snd_in = s; snd_valid = 1'b1;
    hold_m = (int'(s) - 128) * 256;
    step();
    snd_valid = 1'b0;
  endtask

  task automatic stb_model(input string tag);
    logic signed [15:0] v;
    int e;
    wait_stb(v);
    model(hold_m, e);
    chk(tag, v, e);
    chk({tag, "_r"}, $signed(a_r), e);
  endtask

  initial begin
    logic signed [15:0] v;
    int e, first_a, cnt_b, last_b, bad_b;
    rst = 1'b1; snd_in = 8'h5A; snd_valid = 1'b1; mute = 1'b0; vol = 2'd2;
    repeat (3) step();
    chk("rst_l", $signed(a_l), 0);
    chk("rst_r", $signed(a_r), 0);
    chk("rst_stb", a_stb, 0);
    chk("rst_b_stb", b_stb, 0);

    snd_valid = 1'b0; snd_in = 8'h80; vol = 2'd0; rst = 1'b0;
    // n counts edges since release; strobe visible after edge n lies in cycle n+1.
    first_a = -1; cnt_b = 0; last_b = -1; bad_b = 0;
    for (int n = 1; n <= 10001; n++) begin
      step();
      if (a_stb && first_a < 0) first_a = n;
      if (b_stb) begin
        if (last_b >= 0 && n - last_b != 333 && n - last_b != 334) bad_b++;
        cnt_b++;
        last_b = n;
      end
    end
    chk("first_stb_cycle", first_a + 1, 12);
    chk("rate_count", cnt_b, 30);
    chk("rate_spacing_bad", bad_b, 0);

    // Step response: DC blocker pulls 16384 back toward 0.
    stb_model("idle");
    apply(8'hC0);
    wait_stb(v); model(hold_m, e);
    chk("step0", v, 16384);
    chk("step0_r", $signed(a_r), 16384);
    chk("step0_lp2", $signed(c_l), 4096);
    step();
    chk("stb_width", a_stb, 0);
    wait_stb(v); model(hold_m, e);
    chk("step1", v, 15360);
    wait_stb(v); model(hold_m, e);
    chk("step2", v, 14400);
    for (int i = 0; i < 3; i++) stb_model("step_decay");

    // Saturation at VOL=3.
    vol = 2'd3;
    apply(8'h80); stb_model("sat_mid0");
    apply(8'hFF); wait_stb(v); model(hold_m, e);
    chk("sat_pos", v, 32767);
    apply(8'h80); stb_model("sat_mid1");
    apply(8'h00); wait_stb(v); model(hold_m, e);
    chk("sat_neg", v, -32768);

    // Sample lands in the tick cycle: this strobe holds the old lp, the next one the new.
    vol = 2'd0;
    apply(8'h80); stb_model("coin_pre");
    repeat (8) step();
    snd_in = 8'hA0; snd_valid = 1'b1;
    step();
    snd_valid = 1'b0;
    stb_model("coin_old");
    hold_m = 8192;
    stb_model("coin_new");

    // Mute silences output while dc keeps tracking.
    mute = 1'b1;
    apply(8'hC0);
    for (int i = 0; i < 3; i++) stb_model("mute");
    apply(8'h40); stb_model("mute_neg");
    mute = 1'b0;
    stb_model("unmute");

    // Reset while a tick is in flight suppresses its strobe.
    repeat (9) step();
    rst = 1'b1;
    step();
    chk("rst_inflight_stb", a_stb, 0);
    chk("rst_inflight_l", $signed(a_l), 0);
    rst = 1'b0;
    step();
    chk("rst_inflight_stb2", a_stb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
